// File: rtl/conv5x5_mac_pkg.sv
// Shared constants and the requantize helper for the 5x5 conv engine.
package conv_pkg;
  localparam int N_TAPS   = 25;
  localparam int K        = 5;
  localparam int PIX_W    = 8;
  localparam int W_W      = 8;
  localparam int PROD_W   = 17;
  localparam int BIAS_W   = 16;
  localparam int ROW_W    = 20;
  localparam int LOAD_LEN = N_TAPS + 2;
  localparam int SUM_W    = 48;

  // ReLU, arithmetic right shift (truncating), then clamp to 8 bits.
  function automatic logic [7:0] sat_relu(input logic signed [SUM_W-1:0] sum,
                                          input int unsigned shift);
    logic signed [SUM_W-1:0] q;
    q = sum >>> shift;
    if (sum < 0) return 8'h00;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction
endpackage

// File: rtl/conv5x5_mac_if.sv
// Window / kernel-load / result bundle between line buffer, engine and sink.
interface conv5x5_mac_if;
  import conv_pkg::*;
  logic [7:0]                        i_w_data;
  logic                              i_w_valid;
  logic [N_TAPS-1:0][PIX_W-1:0]      i_pix;
  logic                              i_valid;
  logic [7:0]                        o_data;
  logic                              o_valid;
  logic                              o_w_loaded;

  modport master (output i_w_data, i_w_valid, i_pix, i_valid,
                  input  o_data, o_valid, o_w_loaded);
  modport slave  (input  i_w_data, i_w_valid, i_pix, i_valid,
                  output o_data, o_valid, o_w_loaded);
endinterface

// File: rtl/conv5x5_mac_row.sv
// One kernel row: 5 registered products, then a registered row sum.
module conv_row_mac
  import conv_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [K-1:0][PIX_W-1:0]  i_pix,
  input  logic [K-1:0][W_W-1:0]    i_w,
  output logic [ROW_W-1:0]         o_sum
);
  logic [K-1:0][PROD_W-1:0] prod;
  logic signed [ROW_W-1:0]  sum_c;

  // S1: pixel is unsigned, so zero-extend to 9b before the signed multiply.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) prod <= '0;
    else
      for (int k = 0; k < K; k++)
        prod[k] <= PROD_W'($signed({1'b0, i_pix[k]})) * PROD_W'($signed(i_w[k]));
  end

  // Row adder tree input; 5 x 17b signed fits in 20b.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < K; k++) sum_c = sum_c + ROW_W'($signed(prod[k]));
  end

  // S2: register the row sum.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_sum <= '0;
    else        o_sum <= sum_c;
  end
endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 conv MAC: kernel/bias loader, 5 row MACs, bias add, ReLU/requantize.
module conv5x5_mac
  import conv_pkg::*;
#(
  parameter int SHIFT = 8,
  parameter int ACC_W = 22
) (
  input  logic         i_clk,
  input  logic         i_rst,
  conv5x5_mac_if.slave bus
);
  // vld_pipe[0]=products, [1]=row sums, [2]=total, [3]=post, [4]=output
  localparam int STAGES = 4;

  logic [4:0]                   w_cnt;
  logic                         w_loaded;
  logic [N_TAPS-1:0][W_W-1:0]   w_q;
  logic [BIAS_W-1:0]            bias_q;
  logic [STAGES:0]              vld_pipe;
  logic [K-1:0][ROW_W-1:0]      row_sum;
  logic signed [ACC_W-1:0]      tot_c;
  logic signed [ACC_W-1:0]      acc_q;
  logic [7:0]                   post_q;
  logic [7:0]                   data_q;

  // Kernel/bias loader; any byte while loaded restarts at W[0] and drops loaded.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      w_cnt    <= '0;
      w_loaded <= 1'b0;
      w_q      <= '0;
      bias_q   <= '0;
    end else if (bus.i_w_valid) begin
      if (w_cnt < 5'(N_TAPS))       w_q[w_cnt]   <= bus.i_w_data;
      else if (w_cnt == 5'(N_TAPS)) bias_q[7:0]  <= bus.i_w_data;
      else                          bias_q[15:8] <= bus.i_w_data;
      if (w_cnt == 5'(LOAD_LEN-1)) begin
        w_cnt    <= '0;
        w_loaded <= 1'b1;
      end else begin
        w_cnt    <= w_cnt + 5'd1;
        w_loaded <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    conv_row_mac u_row (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_pix (bus.i_pix[r*K +: K]),
      .i_w   (w_q[r*K +: K]),
      .o_sum (row_sum[r])
    );
  end

  // Total of row sums plus sign-extended bias.
  always_comb begin
    tot_c = ACC_W'($signed(bias_q));
    for (int r = 0; r < K; r++) tot_c = tot_c + ACC_W'($signed(row_sum[r]));
  end

  // S3 total, S4 requantize, then output register that holds between results.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q  <= '0;
      post_q <= '0;
      data_q <= '0;
    end else begin
      acc_q  <= tot_c;
      post_q <= sat_relu(SUM_W'(acc_q), SHIFT);
      if (vld_pipe[STAGES-1]) data_q <= post_q;
    end
  end

  // Valid shift register; windows are accepted only with a complete kernel.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], bus.i_valid & w_loaded};
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = vld_pipe[STAGES];
  assign bus.o_w_loaded = w_loaded;
endmodule

// File: tb/tb_conv5x5_mac.sv
// Randomized bench: two engines (SHIFT=0 and SHIFT=8) against a queue model.
module tb_conv5x5_mac;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [7:0]        w_data  = '0;
  logic              w_valid = 1'b0;
  logic              valid   = 1'b0;
  logic [24:0][7:0]  pix     = '0;

  conv5x5_mac_if bus0();
  conv5x5_mac_if bus8();
  assign bus0.i_w_data = w_data;  assign bus8.i_w_data = w_data;
  assign bus0.i_w_valid = w_valid; assign bus8.i_w_valid = w_valid;
  assign bus0.i_valid = valid;    assign bus8.i_valid = valid;
  assign bus0.i_pix = pix;        assign bus8.i_pix = pix;

  conv5x5_mac #(.SHIFT(0), .ACC_W(22)) u_dut0 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus0));
  conv5x5_mac #(.SHIFT(8), .ACC_W(22)) u_dut8 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus8));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference state
  int          mw[25];
  logic [15:0] mb;
  bit          mloaded;
  int          mcnt;
  int          last0, last8;
  typedef struct { int due; int d0; int d8; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got %0d want %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int ref_px(input int s, input int sh);
    int r;
    if (s < 0) return 0;
    r = s >>> sh;
    return (r > 255) ? 255 : r;
  endfunction

  function automatic int ref_sum();
    int s;
    s = int'($signed(mb));
    for (int k = 0; k < 25; k++) s += int'(pix[k]) * mw[k];
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 25; k++) mw[k] = 0;
    mb = '0; mloaded = 0; mcnt = 0; last0 = 0; last8 = 0;
    q.delete();
  endtask

  // One clock: model the edge with pre-edge state, then check #1 after.
  task automatic step();
    exp_t e;
    int s;
    @(posedge i_clk);
    cyc++;
    if (valid && mloaded) begin
      s = ref_sum();
      e.due = cyc + 4; e.d0 = ref_px(s, 0); e.d8 = ref_px(s, 8);
      q.push_back(e);
    end
    if (w_valid) begin
      if (mcnt < 25)       mw[mcnt] = int'($signed(w_data));
      else if (mcnt == 25) mb[7:0]  = w_data;
      else                 mb[15:8] = w_data;
      if (mcnt == 26) begin mcnt = 0; mloaded = 1; end
      else begin mcnt++; mloaded = 0; end
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("ovalid0", int'(bus0.o_valid), 1);
      chk("ovalid8", int'(bus8.o_valid), 1);
      chk("odata0", int'(bus0.o_data), q[0].d0);
      chk("odata8", int'(bus8.o_data), q[0].d8);
      last0 = q[0].d0; last8 = q[0].d8;
      void'(q.pop_front());
    end else begin
      chk("ovalid0_idle", int'(bus0.o_valid), 0);
      chk("ovalid8_idle", int'(bus8.o_valid), 0);
      chk("ohold0", int'(bus0.o_data), last0);
      chk("ohold8", int'(bus8.o_data), last8);
    end
    chk("wloaded", int'(bus0.o_w_loaded), int'(mloaded));
  endtask

  task automatic load(input logic [7:0] b[27]);
    for (int i = 0; i < 27; i++) begin
      w_data = b[i]; w_valid = 1'b1; step();
    end
    w_valid = 1'b0;
  endtask

  task automatic load_const(input logic [7:0] w, input logic [15:0] bias);
    logic [7:0] b[27];
    for (int i = 0; i < 25; i++) b[i] = w;
    b[25] = bias[7:0]; b[26] = bias[15:8];
    load(b);
  endtask

  task automatic load_rand();
    logic [7:0] b[27];
    for (int i = 0; i < 27; i++) b[i] = 8'($urandom);
    load(b);
  endtask

  task automatic win_const(input logic [7:0] p);
    for (int k = 0; k < 25; k++) pix[k] = p;
    valid = 1'b1; step(); valid = 1'b0;
    repeat (5) step();
  endtask

  task automatic rand_pix();
    for (int k = 0; k < 25; k++) pix[k] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] rb[27];
    int bi;
    model_clear();
    #2;
    chk("rst_odata", int'(bus0.o_data), 0);
    chk("rst_ovalid", int'(bus0.o_valid), 0);
    chk("rst_wloaded", int'(bus8.o_w_loaded), 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b1;

    // directed arithmetic cases
    load_const(8'h01, 16'h0000);
    win_const(8'h01);
    win_const(8'hFF);
    load_const(8'hFF, 16'h0000);
    win_const(8'h10);
    load_const(8'h00, 16'h0064);
    win_const(8'h37);
    load_const(8'h00, 16'hFF9C);
    win_const(8'h37);

    // partial load with windows offered throughout, then completion
    load_rand();
    valid = 1'b1; rand_pix();
    w_valid = 1'b1;
    for (int i = 0; i < 26; i++) begin w_data = 8'($urandom_range(0, 7)); step(); rand_pix(); end
    w_valid = 1'b0;
    repeat (4) begin step(); rand_pix(); end
    w_data = 8'h00; w_valid = 1'b1; step(); w_valid = 1'b0;
    rand_pix(); step();
    valid = 1'b0;
    repeat (5) step();

    // 10 back-to-back windows
    for (int i = 0; i < 10; i++) begin rand_pix(); valid = 1'b1; step(); end
    valid = 1'b0;
    repeat (5) step();

    // reload starting mid-stream
    for (int i = 0; i < 27; i++) rb[i] = 8'($urandom);
    bi = 0;
    for (int i = 0; i < 10; i++) begin
      rand_pix(); valid = 1'b1;
      if (i >= 5) begin w_valid = 1'b1; w_data = rb[bi]; bi++; end
      step();
    end
    valid = 1'b0;
    while (bi < 27) begin w_valid = 1'b1; w_data = rb[bi]; bi++; step(); end
    w_valid = 1'b0;
    repeat (5) step();

    // random traffic
    for (int rnd = 0; rnd < 3; rnd++) begin
      load_rand();
      for (int i = 0; i < 80; i++) begin
        rand_pix(); valid = ($urandom_range(0, 3) != 0); step();
      end
      valid = 1'b0;
      repeat (5) step();
    end

    // async reset with 3 windows in flight
    for (int i = 0; i < 3; i++) begin rand_pix(); valid = 1'b1; step(); end
    #1 i_rst = 1'b0;
    #1;
    chk("mrst_odata0", int'(bus0.o_data), 0);
    chk("mrst_odata8", int'(bus8.o_data), 0);
    chk("mrst_ovalid", int'(bus0.o_valid), 0);
    chk("mrst_wloaded", int'(bus0.o_w_loaded), 0);
    model_clear();
    #3 i_rst = 1'b1;
    repeat (8) begin rand_pix(); step(); end
    valid = 1'b0;
    load_const(8'h02, 16'h0010);
    win_const(8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv5x5_mac.md
# conv5x5_mac

Pipelined 5x5 convolution engine for the first conv layer. It sits directly downstream of the 28-wide line buffer and consumes one 25-pixel window per valid cycle. It multiplies the window by a locally stored signed 5x5 kernel, adds a bias, applies ReLU, requantizes and saturates, and emits one 8-bit feature-map pixel per accepted window.

## Interface
- Parameters:
- SHIFT, 8, arithmetic right-shift applied after ReLU (0..15)
- ACC_W, 22, accumulator width (fixed minimum 22; larger allowed)
- Ports:
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  reset; one clock, reset asynchronous and active-low
- i_w_data  in  8  kernel/bias load byte
- i_w_valid  in  1  load strobe; one byte per cycle
- i_pix  in  200  window; pixel k (k=0..24, row-major, k=0 top-left) at bits [8k+7:8k], unsigned
- i_valid  in  1  window valid
- o_data  out  8  output pixel, unsigned
- o_valid  out  1  output valid, one-cycle pulse per accepted window
- o_w_loaded  out  1  kernel and bias fully loaded

## Operation
- Load sequence is 27 bytes, tracked by counter w_cnt (0..26):
  - Bytes 0..24 are weights W[0..24], signed two's complement, row-major.
  - Byte 25 is bias[7:0]; byte 26 is bias[15:8] (bias is 16-bit signed).
- On byte 26, w_cnt wraps to 0 and o_w_loaded rises the next cycle.
- A load byte arriving while o_w_loaded=1 starts a reload: it writes W[0], and o_w_loaded falls on the same edge.
- A window is accepted on an edge where i_valid=1 and o_w_loaded=1. Otherwise it is dropped silently and produces no output.
- A window accepted on the same edge as the first reload byte uses the old weights, because the products register from pre-edge weights.
- Arithmetic:
  - Each product is zero-extended pixel (9b signed) × W (8b signed), giving a 17b signed product.
  - Sum = Σ products + sign-extended bias, held in ACC_W bits signed. It cannot overflow: |Σ| ≤ 816000 + 32768.
  - Post: if sum<0 then 0, else sum>>>SHIFT (truncating). If the result is >255 then 255.
- Pipeline (4 stages, each with a valid bit):
  - S1: register 25 products.
  - S2: register 5 row sums.
  - S3: register the total plus bias.
  - S4: register o_data after ReLU, shift and saturate.
- Throughput is one window per cycle with no stalls. There is no backpressure; downstream must accept every o_valid.

## Timing
- Reset (asynchronous assert) sets every output to 0: o_data=0, o_valid=0, o_w_loaded=0.
- Reset also clears w_cnt=0, all weights and bias to 0, and all stage valid bits to 0.
- Reset deassertion is synchronous to i_clk.
- Reset mid-pipeline discards in-flight windows. Weights must then be reloaded before any output.
- Latency: a window accepted at edge t gives o_valid=1 with its result at edge t+4.
  - o_valid is high exactly during cycle t+4..t+5.
  - o_data holds its last value when o_valid=0.
- Load: the 27th byte is written at edge t; o_w_loaded=1 from edge t+1. A window at edge t+1 is accepted.
- A partial load (fewer than 27 bytes) leaves o_w_loaded=0 indefinitely. Further bytes continue the count.

## Structure
- Package conv_pkg holds:
  - N_TAPS=25, K=5, PIX_W=8, W_W=8, PROD_W=17, BIAS_W=16.
  - A function sat_relu(sum, shift) returning 8b.
- Sub-module conv_row_mac (instantiated 5×) covers S1+S2 for one kernel row:
  - Inputs are 5 pixels and 5 weights.
  - It registers the 5 products and then a registered 20b row sum.
- The top level owns:
  - the load counter and weight/bias registers,
  - the S3 adder and S4 post-processing,
  - the valid pipeline.

## Test plan
- Load 25×0x01 plus bias 0x0000, SHIFT=0, then one window of all 0x01 → o_valid 4 cycles later with o_data=25.
- Same weights with all pixels 0xFF: SHIFT=0 → 255 (sum 6375 saturates); SHIFT=8 → 24.
- Weights all 0xFF (−1) with pixels 0x10 → sum −400 → o_data=0. Weights 0 with bias 0x0064 → 100; bias 0xFF9C → 0.
- Set i_valid=1 before and during a partial load of 26 bytes → no o_valid. After the 27th byte, the first window accepted the next cycle gives output at +4.
- Stream 10 back-to-back windows with distinct values → 10 consecutive o_valid cycles, results in order. Start a reload mid-stream → windows up to and including the first reload-byte edge give old-weight results, and later windows are dropped.
- Assert i_rst for half a cycle with 3 windows in flight → all outputs 0 immediately, no o_valid afterwards, and o_w_loaded=0 until a full reload.
